// File: rtl/decode_stage_if.sv
// Fetch-beat type plus the bundled upstream/downstream handshake for the decode stage.
// The slave modport is the decode stage's side; master is the driving environment.
package decode_stage_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] instr;
    } fetch_data;
endpackage

interface decode_stage_if;
    import decode_stage_pkg::*;

    logic        flush;
    logic        valid_in;
    fetch_data   data_in;
    logic        ready_in;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] pc_out;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic [1:0]  fu_type;
    logic        illegal;
    logic [31:0] decode_count;

    modport slave (
        input  flush, valid_in, data_in, ready_out,
        output ready_in, valid_out, pc_out, rd, rs1, rs2, imm,
               uses_rs1, uses_rs2, writes_rd, fu_type, illegal, decode_count
    );

    modport master (
        output flush, valid_in, data_in, ready_out,
        input  ready_in, valid_out, pc_out, rd, rs1, rs2, imm,
               uses_rs1, uses_rs2, writes_rd, fu_type, illegal, decode_count
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes an accepted fetch beat into a single registered slot
// for rename, with valid/ready backpressure toward fetch and a flush that empties the slot.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam logic [1:0] FU_ALU    = 2'd0;
    localparam logic [1:0] FU_BRANCH = 2'd1;
    localparam logic [1:0] FU_LSU    = 2'd2;
    localparam logic [1:0] FU_NONE   = 2'd3;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_imm;
    logic        w_uses_rs1, w_uses_rs2, w_rd_field_used, w_writes_rd;
    logic [1:0]  w_fu_type;
    logic        w_illegal;
    logic        w_ready_in;
    logic        w_accept;
    logic        w_unused_pc_4;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [31:0] r_imm;
    logic        r_uses_rs1, r_uses_rs2, r_writes_rd;
    logic [1:0]  r_fu_type;
    logic        r_illegal;
    logic [31:0] r_decode_count;

    assign w_instr       = bus.data_in.instr;
    assign w_opcode      = w_instr[6:0];
    assign w_unused_pc_4 = ^bus.data_in.pc_4;

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    always_comb begin
        w_fu_type       = FU_NONE;
        w_illegal       = 1'b0;
        w_uses_rs1      = 1'b0;
        w_uses_rs2      = 1'b0;
        w_rd_field_used = 1'b0;
        w_imm           = 32'd0;
        case (w_opcode)
            OP_OP: begin
                w_fu_type = FU_ALU; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_rd_field_used = 1'b1;
            end
            OP_OPIMM: begin
                w_fu_type = FU_ALU; w_uses_rs1 = 1'b1; w_rd_field_used = 1'b1; w_imm = w_imm_i;
            end
            OP_LUI, OP_AUIPC: begin
                w_fu_type = FU_ALU; w_rd_field_used = 1'b1; w_imm = w_imm_u;
            end
            OP_JAL: begin
                w_fu_type = FU_BRANCH; w_rd_field_used = 1'b1; w_imm = w_imm_j;
            end
            OP_JALR: begin
                w_fu_type = FU_BRANCH; w_uses_rs1 = 1'b1; w_rd_field_used = 1'b1; w_imm = w_imm_i;
            end
            OP_BRANCH: begin
                w_fu_type = FU_BRANCH; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_imm = w_imm_b;
            end
            OP_LOAD: begin
                w_fu_type = FU_LSU; w_uses_rs1 = 1'b1; w_rd_field_used = 1'b1; w_imm = w_imm_i;
            end
            OP_STORE: begin
                w_fu_type = FU_LSU; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_imm = w_imm_s;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // x0 is never a real destination, so rename must not allocate for it.
    assign w_writes_rd = w_rd_field_used && (w_instr[11:7] != 5'd0);

    assign w_ready_in = !bus.flush && (!r_valid || bus.ready_out);
    assign w_accept   = bus.valid_in && w_ready_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_pc           <= 32'd0;
            r_rd           <= 5'd0;
            r_rs1          <= 5'd0;
            r_rs2          <= 5'd0;
            r_imm          <= 32'd0;
            r_uses_rs1     <= 1'b0;
            r_uses_rs2     <= 1'b0;
            r_writes_rd    <= 1'b0;
            r_fu_type      <= FU_NONE;
            r_illegal      <= 1'b0;
            r_decode_count <= 32'd0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid        <= 1'b1;
            r_pc           <= bus.data_in.pc;
            r_rd           <= w_instr[11:7];
            r_rs1          <= w_instr[19:15];
            r_rs2          <= w_instr[24:20];
            r_imm          <= w_imm;
            r_uses_rs1     <= w_uses_rs1;
            r_uses_rs2     <= w_uses_rs2;
            r_writes_rd    <= w_writes_rd;
            r_fu_type      <= w_fu_type;
            r_illegal      <= w_illegal;
            r_decode_count <= r_decode_count + 32'd1;
        end else if (bus.ready_out) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ready_in     = w_ready_in;
    assign bus.valid_out    = r_valid;
    assign bus.pc_out       = r_pc;
    assign bus.rd           = r_rd;
    assign bus.rs1          = r_rs1;
    assign bus.rs2          = r_rs2;
    assign bus.imm          = r_imm;
    assign bus.uses_rs1     = r_uses_rs1;
    assign bus.uses_rs2     = r_uses_rs2;
    assign bus.writes_rd    = r_writes_rd;
    assign bus.fu_type      = r_fu_type;
    assign bus.illegal      = r_illegal;
    assign bus.decode_count = r_decode_count;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a reference decoder feeds a scoreboard queue on every
// modelled accept, and each held slot is compared against the queue head.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        u1, u2, wr;
        logic [1:0]  fu;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t        sb[$];
    logic        m_valid = 1'b0;
    logic        m_acc   = 1'b0;
    logic [31:0] m_count = 32'd0;

    decode_stage_if bus();
    decode_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        logic s;
        s = ins[31];
        e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        e.imm = 32'd0; e.u1 = 0; e.u2 = 0; e.wr = 0; e.fu = 2'd3; e.ill = 0;
        unique case (ins[6:0])
            7'h33: begin e.fu = 0; e.u1 = 1; e.u2 = 1; e.wr = 1; end
            7'h13: begin e.fu = 0; e.u1 = 1; e.wr = 1; e.imm = {{20{s}}, ins[31:20]}; end
            7'h37, 7'h17: begin e.fu = 0; e.wr = 1; e.imm = ins & 32'hFFFFF000; end
            7'h6F: begin e.fu = 1; e.wr = 1;
                   e.imm = {{12{s}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
            7'h67: begin e.fu = 1; e.u1 = 1; e.wr = 1; e.imm = {{20{s}}, ins[31:20]}; end
            7'h63: begin e.fu = 1; e.u1 = 1; e.u2 = 1;
                   e.imm = {{20{s}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
            7'h03: begin e.fu = 2; e.u1 = 1; e.wr = 1; e.imm = {{20{s}}, ins[31:20]}; end
            7'h23: begin e.fu = 2; e.u1 = 1; e.u2 = 1; e.imm = {{20{s}}, ins[31:25], ins[11:7]}; end
            default: e.ill = 1;
        endcase
        if (e.rd == 5'd0) e.wr = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        bus.valid_in      = v;
        bus.data_in.pc    = pc;
        bus.data_in.pc_4  = pc + 32'd4;
        bus.data_in.instr = ins;
    endtask

    // One clock: check at the falling edge, advance the model, return 1 time unit after the rising edge.
    task automatic cycle();
        logic exp_ready;
        exp_t h;
        @(negedge clk);
        exp_ready = !bus.flush && (!m_valid || bus.ready_out);
        chk("ready_in", 32'(bus.ready_in), 32'(exp_ready));
        chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
        chk("decode_count", bus.decode_count, m_count);
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'(sb.size()), 32'd1);
            end else begin
                h = sb[0];
                chk("pc_out", bus.pc_out, h.pc);
                chk("rd", 32'(bus.rd), 32'(h.rd));
                chk("rs1", 32'(bus.rs1), 32'(h.rs1));
                chk("rs2", 32'(bus.rs2), 32'(h.rs2));
                chk("imm", bus.imm, h.imm);
                chk("flags", {29'd0, bus.uses_rs1, bus.uses_rs2, bus.writes_rd}, {29'd0, h.u1, h.u2, h.wr});
                chk("fu_type", 32'(bus.fu_type), 32'(h.fu));
                chk("illegal", 32'(bus.illegal), 32'(h.ill));
            end
        end
        m_acc = 1'b0;
        if (bus.flush) begin
            m_valid = 1'b0;
            sb.delete();
        end else begin
            if (m_valid && bus.ready_out && sb.size() != 0) void'(sb.pop_front());
            if (bus.valid_in && exp_ready) begin
                sb.push_back(ref_decode(bus.data_in.pc, bus.data_in.instr));
                m_valid = 1'b1;
                m_acc   = 1'b1;
                m_count = m_count + 32'd1;
            end else if (bus.ready_out) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  ops [9];
    logic [31:0] stream_ins [8];
    logic [31:0] r;
    int          k, stall;

    initial begin
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h7F};
        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            stream_ins[i] = {r[31:7], ops[$urandom_range(0, 8)]};
        end

        reset = 1'b1;
        bus.flush = 1'b0; bus.ready_out = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        #2;
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_ready_in", 32'(bus.ready_in), 32'd1);
        chk("rst_pc_out", bus.pc_out, 32'd0);
        chk("rst_imm", bus.imm, 32'd0);
        chk("rst_regs", {17'd0, bus.rd, bus.rs1, bus.rs2}, 32'd0);
        chk("rst_flags", {28'd0, bus.uses_rs1, bus.uses_rs2, bus.writes_rd, bus.illegal}, 32'd0);
        chk("rst_fu_type", 32'(bus.fu_type), 32'd3);
        chk("rst_count", bus.decode_count, 32'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // Directed decodes, each also checked against fixed expected values.
        drive(1'b1, 32'h0, 32'h00500093); cycle();
        chk("addi_valid", 32'(bus.valid_out), 32'd1);
        chk("addi_rd", 32'(bus.rd), 32'd1);
        chk("addi_rs1", 32'(bus.rs1), 32'd0);
        chk("addi_imm", bus.imm, 32'd5);
        chk("addi_fu", 32'(bus.fu_type), 32'd0);
        chk("addi_wr_u2", {30'd0, bus.writes_rd, bus.uses_rs2}, 32'd2);
        chk("addi_count", bus.decode_count, 32'd1);

        drive(1'b1, 32'h4, 32'hFE000EE3); cycle();
        chk("beq_imm", bus.imm, 32'hFFFFFFFC);
        chk("beq_fu", 32'(bus.fu_type), 32'd1);
        chk("beq_flags", {29'd0, bus.uses_rs1, bus.uses_rs2, bus.writes_rd}, 32'd6);

        drive(1'b1, 32'h8, 32'h0020A423); cycle();
        chk("sw_imm", bus.imm, 32'd8);
        chk("sw_rs", {22'd0, bus.rs1, bus.rs2}, {22'd0, 5'd1, 5'd2});
        chk("sw_fu", 32'(bus.fu_type), 32'd2);

        drive(1'b1, 32'hC, 32'h123452B7); cycle();
        chk("lui_imm", bus.imm, 32'h12345000);
        chk("lui_rd", 32'(bus.rd), 32'd5);

        drive(1'b1, 32'h10, 32'h00000000); cycle();
        chk("zero_illegal", 32'(bus.illegal), 32'd1);
        chk("zero_fu", 32'(bus.fu_type), 32'd3);

        drive(1'b0, 32'h0, 32'h0); cycle();

        // Stream 8 beats with a 3-cycle downstream stall after the second accept.
        k = 0; stall = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            bus.ready_out = (stall == 0);
            drive(1'b1, 32'(k) * 32'd4, stream_ins[k]);
            if (stall > 0) chk("stall_pc", bus.pc_out, 32'h4);
            cycle();
            if (stall > 0) stall--;
            if (m_acc) begin
                k++;
                if (k == 2) stall = 3;
            end
        end
        chk("stream_beats", 32'(k), 32'd8);
        bus.ready_out = 1'b1;
        drive(1'b0, 32'h0, 32'h0); cycle();
        cycle();

        // Flush while the slot is held full and a beat is pending.
        bus.ready_out = 1'b0;
        drive(1'b1, 32'h100, 32'h00A00513); cycle();
        drive(1'b1, 32'h104, 32'h00B00593); cycle();
        chk("pre_flush_count", bus.decode_count, 32'd14);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_valid_out", 32'(bus.valid_out), 32'd0);
        chk("flush_count", bus.decode_count, 32'd14);
        bus.flush = 1'b1; cycle();
        bus.flush = 1'b0; cycle();
        bus.ready_out = 1'b1;

        // Asynchronous reset between edges while the slot is full.
        bus.ready_out = 1'b0;
        drive(1'b1, 32'h200, 32'h00100113); cycle();
        drive(1'b0, 32'h0, 32'h0);
        chk("pre_rst_valid", 32'(bus.valid_out), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.valid_out), 32'd0);
        chk("async_rst_count", bus.decode_count, 32'd0);
        chk("async_rst_fu", 32'(bus.fu_type), 32'd3);
        reset = 1'b0;
        m_valid = 1'b0; m_count = 32'd0; sb.delete();
        bus.ready_out = 1'b1;
        cycle();
        drive(1'b1, 32'h300, 32'h0000A183); cycle();
        drive(1'b0, 32'h0, 32'h0); cycle();
        chk("post_rst_count", bus.decode_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Consumer end of the fetch valid/ready interface: accepts `fetch_data` beats (pc, pc_4, instr) from the fetch skid buffer. Decodes each RV32I instruction into register, immediate and functional-unit fields, and holds the result in a single registered output slot for rename. The block provides backpressure toward fetch and supports a branch/exception flush.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `flush`  in  1  pipeline flush; discards the held beat and blocks acceptance for this cycle.
- `valid_in`  in  1  upstream beat valid.
- `data_in`  in  `fetch_data`  upstream beat {pc, pc_4, instr}.
- `ready_in`  out  1  block can accept a beat this cycle.
- `valid_out`  out  1  decoded beat held for downstream.
- `ready_out`  in  1  downstream accepts the held beat this cycle.
- `pc_out`  out  32  PC of the held instruction.
- `rd`, `rs1`, `rs2`  out  5 each  register indices taken from instr[11:7], [19:15] and [24:20].
- `imm`  out  32  sign-extended immediate.
- `uses_rs1`, `uses_rs2`, `writes_rd`  out  1 each  operand/destination usage flags.
- `fu_type`  out  2  functional unit: 0 = ALU, 1 = BRANCH, 2 = LSU, 3 = none.
- `illegal`  out  1  unsupported opcode.
- `decode_count`  out  32  number of beats accepted since reset; wraps modulo 2^32.

## Operation
- Single output slot: a beat is accepted when `valid_in && ready_in`, and is decoded combinationally from `data_in` into the slot at that edge.
- Transfer completes on `valid_out && ready_out`.
- Readiness: `ready_in = !flush && (!valid_out || ready_out)`. This is combinational, so back-to-back beats stream at 1 beat/cycle while downstream is ready.
- Slot update priority at each edge:
  1. `flush`: `valid_out` <= 0, no accept.
  2. Accept: load the new beat, `valid_out` <= 1.
  3. Downstream takes the beat with no new beat arriving: `valid_out` <= 0.
  4. Otherwise hold; all outputs stay stable while `valid_out && !ready_out`.
- Opcode decode:
  - `0110011` OP: ALU; rs1, rs2, rd; imm = 0.
  - `0010011` OP-IMM: ALU; rs1, rd; I-imm.
  - `0110111` LUI and `0010111` AUIPC: ALU; rd; U-imm (instr[31:12] << 12).
  - `1101111` JAL: BRANCH; rd; J-imm.
  - `1100111` JALR: BRANCH; rs1, rd; I-imm.
  - `1100011` BRANCH: BRANCH; rs1, rs2; B-imm.
  - `0000011` LOAD: LSU; rs1, rd; I-imm.
  - `0100011` STORE: LSU; rs1, rs2; S-imm.
  - Any other opcode: `fu_type` = 3, `illegal` = 1, all usage flags 0, imm = 0.
- `writes_rd` is forced to 0 when rd == 0.
- `rd`, `rs1`, `rs2` are always the raw instruction fields, independent of the usage flags.
- All immediates are sign-extended from instr[31].
- `decode_count` increments by 1 on every accept. Flush does not decrement it.

## Timing
- Reset values: `valid_out` = 0; `pc_out`, `rd`, `rs1`, `rs2`, `imm`, `decode_count` = 0; all flags = 0; `fu_type` = 3; `ready_in` = 1 (when `flush` = 0).
- Latency: 1 cycle from accept edge to `valid_out` = 1 with decoded fields.
- Full slot with `ready_out` = 0: `ready_in` = 0; an upstream beat must stay pending in the skid buffer.
- Full slot with `ready_out` = 1 and `valid_in` = 1: drain and refill happen at the same edge; `valid_out` stays 1.
- `flush` together with `valid_in`: the incoming beat is not accepted and the slot is empty at the next edge. `flush` while empty has no effect on outputs.
- Reset asserted mid-stream: all outputs return to their reset values immediately (asynchronous), independent of `clk`.

## Test plan
- After reset, drive `valid_in` = 1, pc = 0x0, instr = 0x00500093 with `ready_out` = 1 -> next cycle: `valid_out` = 1, `rd` = 1, `rs1` = 0, `imm` = 5, `fu_type` = 0, `writes_rd` = 1, `uses_rs2` = 0, `decode_count` = 1.
- Drive instr 0xFE000EE3 (beq x0,x0,-4) at pc 0x4 -> `imm` = 0xFFFFFFFC, `fu_type` = 1, `uses_rs1` = 1, `uses_rs2` = 1, `writes_rd` = 0.
- Drive instr 0x0020A423 (sw x2,8(x1)) -> `imm` = 8, `rs1` = 1, `rs2` = 2, `fu_type` = 2. Then drive instr 0x123452B7 (lui) -> `imm` = 0x12345000, `rd` = 5. Then drive instr 0x00000000 -> `illegal` = 1, `fu_type` = 3.
- Stream pc 0x0 to 0x1C with `ready_out` held low for 3 cycles after the 2nd beat -> `ready_in` = 0 during the stall and outputs stay fixed at pc 0x4. After release, pcs arrive in order with no loss or duplication, 1 beat/cycle.
- Hold the slot full with `ready_out` = 0, then assert `flush` for 1 cycle while `valid_in` = 1 -> `ready_in` = 0 in the flush cycle, `valid_out` = 0 the next cycle, and `decode_count` is unchanged by the dropped beat.
- Assert `reset` asynchronously between clock edges while `valid_out` = 1 -> `valid_out` and `decode_count` read 0 before the next rising edge.
